// File: rtl/touch_ctrl.sv
// Two-pad touch controller: chord grace window, press/release debounce and a
// single-entry event buffer with a sticky overflow flag.
//
// state   | meaning
// IDLE    | no pad touched, waiting for first contact
// CHORD   | grace window, a second pad may still join the touch
// PRESS   | candidate code must stay stable for the debounce time
// HELD    | button reported, watching for the candidate to drop
// RELEASE | candidate lost, must stay lost for the debounce time
module touch_ctrl #(
  parameter int CHORD_CYCLES    = 480_000,
  parameter int DEBOUNCE_CYCLES = 240_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_left,
  input  logic       i_right,
  output logic [2:0] o_btn,
  output logic       o_evt_valid,
  output logic [2:0] o_evt_data,
  input  logic       i_evt_ready,
  output logic       o_ovf
);

  localparam int CNT_MAX = (CHORD_CYCLES > DEBOUNCE_CYCLES) ? CHORD_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CHORD_LAST = CW'(CHORD_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHORD,
    S_PRESS,
    S_HELD,
    S_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      cand_q, cand_d;
  logic [2:0]      btn_q, btn_d;
  logic            evt_valid_q, evt_valid_d;
  logic [2:0]      evt_data_q, evt_data_d;
  logic            ovf_q, ovf_d;

  logic [1:0]      raw;
  logic            issue;
  logic [2:0]      issue_data;

  assign raw = {~i_right, ~i_left};

  function automatic logic [2:0] onehot(input logic [1:0] code);
    case (code)
      2'b01:   return 3'b001;
      2'b10:   return 3'b010;
      2'b11:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    btn_d      = btn_q;
    issue      = 1'b0;
    issue_data = {1'b0, cand_q};
    case (state_q)
      S_IDLE: begin
        if (raw != 2'b00) begin
          state_d = S_CHORD;
          cnt_d   = '0;
          cand_d  = raw;
        end
      end
      S_CHORD: begin
        if (raw == 2'b00) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          // once both pads have been seen the touch is a chord for good
          cand_d = (raw == 2'b11 || cand_q == 2'b11) ? 2'b11 : raw;
          if (cnt_q == CHORD_LAST) begin
            state_d = S_PRESS;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_PRESS: begin
        if (raw != cand_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d    = S_HELD;
          cnt_d      = '0;
          btn_d      = onehot(cand_q);
          issue      = 1'b1;
          issue_data = {1'b1, cand_q};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HELD: begin
        if (raw != cand_q) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end
      end
      S_RELEASE: begin
        if (raw == cand_q) begin
          state_d = S_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          btn_d      = 3'b000;
          issue      = 1'b1;
          issue_data = {1'b0, cand_q};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // single-entry buffer: a handshake in the same cycle frees the slot for the new event
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_data_d  = evt_data_q;
    ovf_d       = ovf_q;
    if (evt_valid_q && i_evt_ready) evt_valid_d = 1'b0;
    if (issue) begin
      if (!evt_valid_q || i_evt_ready) begin
        evt_valid_d = 1'b1;
        evt_data_d  = issue_data;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cand_q      <= 2'b00;
      btn_q       <= 3'b000;
      evt_valid_q <= 1'b0;
      evt_data_q  <= 3'b000;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      btn_q       <= btn_d;
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_btn       = btn_q;
  assign o_evt_valid = evt_valid_q;
  assign o_evt_data  = evt_data_q;
  assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_touch_ctrl.sv
// Bench for touch_ctrl: sample-window reference model checked every cycle,
// plus directed scenarios with hand-computed event sequences.
module tb_touch_ctrl;

  localparam int C = 4;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_left = 1'b1;
  logic       i_right = 1'b1;
  logic       i_evt_ready = 1'b1;
  logic [2:0] o_btn;
  logic       o_evt_valid;
  logic [2:0] o_evt_data;
  logic       o_ovf;

  touch_ctrl #(.CHORD_CYCLES(C), .DEBOUNCE_CYCLES(D)) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_left      (i_left),
    .i_right     (i_right),
    .o_btn       (o_btn),
    .o_evt_valid (o_evt_valid),
    .o_evt_data  (o_evt_data),
    .i_evt_ready (i_evt_ready),
    .o_ovf       (o_ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int btn2_cycles = 0;

  // reference model state
  logic [1:0] hist[$];   // samples of the current press attempt, first sample at index 0
  logic [1:0] m_code = 2'b00;
  int         m_mis = 0;
  logic       m_valid = 1'b0;
  logic [2:0] m_data = 3'b000;
  logic       m_ovf = 1'b0;
  logic [2:0] got[$];    // events actually handed over by the DUT

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] onehot3(input logic [1:0] c);
    case (c)
      2'b01:   return 3'b001;
      2'b10:   return 3'b010;
      2'b11:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // chord result: both pads if they were ever seen together in the window, else the last sample
  function automatic logic [1:0] chord_code();
    for (int i = 0; i <= C; i++) if (hist[i] == 2'b11) return 2'b11;
    return hist[C];
  endfunction

  task automatic model_step(input logic [1:0] raw, input logic rdy);
    logic       iss;
    logic [2:0] idata;
    logic       was_valid;
    iss   = 1'b0;
    idata = 3'b000;
    if (m_code == 2'b00) begin
      hist.push_back(raw);
      if (raw == 2'b00) hist.delete();
      else if (hist.size() > C + 1 && raw != chord_code()) hist.delete();
      else if (hist.size() == 1 + C + D) begin
        iss    = 1'b1;
        m_code = chord_code();
        idata  = {1'b1, m_code};
        m_mis  = 0;
        hist.delete();
      end
    end else begin
      if (raw == m_code) m_mis = 0;
      else m_mis++;
      if (m_mis == D + 1) begin
        iss    = 1'b1;
        idata  = {1'b0, m_code};
        m_code = 2'b00;
        m_mis  = 0;
      end
    end
    was_valid = m_valid;
    if (was_valid && rdy) m_valid = 1'b0;
    if (iss) begin
      if (!was_valid || rdy) begin
        m_valid = 1'b1;
        m_data  = idata;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic l, input logic r, input logic rdy, input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      i_left      = l;
      i_right     = r;
      i_evt_ready = rdy;
    end
  endtask

  task automatic chk_events(input string name, input int base, input int n,
                            input logic [2:0] e0, input logic [2:0] e1);
    int a;
    chk({name, "_count"}, got.size() - base, n);
    if (n > 0) begin
      a = (got.size() > base) ? int'(got[base]) : -1;
      chk({name, "_ev0"}, a, int'(e0));
    end
    if (n > 1) begin
      a = (got.size() > base + 1) ? int'(got[base + 1]) : -1;
      chk({name, "_ev1"}, a, int'(e1));
    end
  endtask

  int base;
  int b2;

  initial begin
    fork
      // reference model, advanced on the same edges as the DUT
      forever begin
        @(posedge clk or negedge i_rst_n);
        if (!i_rst_n) begin
          hist.delete();
          m_code  = 2'b00;
          m_mis   = 0;
          m_valid = 1'b0;
          m_data  = 3'b000;
          m_ovf   = 1'b0;
        end else begin
          if (o_evt_valid && i_evt_ready) got.push_back(o_evt_data);
          model_step({~i_right, ~i_left}, i_evt_ready);
        end
      end

      // per-cycle comparison against the model
      forever begin
        @(negedge clk);
        chk("btn", int'(o_btn), int'(onehot3(m_code)));
        chk("evt_valid", int'(o_evt_valid), int'(m_valid));
        chk("evt_data", int'(o_evt_data), int'(m_data));
        chk("ovf", int'(o_ovf), int'(m_ovf));
        chk("btn_onehot", int'($countones(o_btn) <= 1), 1);
        if (o_btn == 3'b010) btn2_cycles++;
      end

      // directed scenarios
      begin
        drive(1, 1, 1, 3);
        chk("rst_btn", int'(o_btn), 0);
        chk("rst_valid", int'(o_evt_valid), 0);
        chk("rst_data", int'(o_evt_data), 0);
        chk("rst_ovf", int'(o_ovf), 0);
        @(negedge clk); #1; i_rst_n = 1'b1;

        // single LEFT press: button appears on the 8th low sample (1 + 4 + 3)
        base = got.size();
        drive(0, 1, 1, 7);
        @(posedge clk); #1;
        chk("left_btn_early", int'(o_btn), 0);
        drive(0, 1, 1, 1);
        @(posedge clk); #1;
        chk("left_btn", int'(o_btn), 1);
        chk("left_press_valid", int'(o_evt_valid), 1);
        chk("left_press_data", int'(o_evt_data), 5);
        drive(0, 1, 1, 12);
        drive(1, 1, 1, 10);
        chk_events("left", base, 2, 3'b101, 3'b001);
        chk("left_ovf", int'(o_ovf), 0);

        // RIGHT then LEFT two samples later: chord only
        base = got.size();
        b2   = btn2_cycles;
        drive(1, 0, 1, 2);
        drive(0, 0, 1, 20);
        @(posedge clk); #1;
        chk("chord_btn", int'(o_btn), 4);
        drive(1, 1, 1, 10);
        chk("chord_no_btn2", btn2_cycles - b2, 0);
        chk_events("chord", base, 2, 3'b111, 3'b011);

        // short glitch and short release gap
        base = got.size();
        drive(0, 1, 1, 2);
        drive(1, 1, 1, 10);
        chk("glitch_btn", int'(o_btn), 0);
        chk_events("glitch", base, 0, 3'b000, 3'b000);
        drive(0, 1, 1, 15);
        drive(1, 1, 1, 2);
        drive(0, 1, 1, 10);
        chk("gap_btn", int'(o_btn), 1);
        chk_events("gap_held", base, 1, 3'b101, 3'b000);
        drive(1, 1, 1, 10);
        chk_events("gap", base, 2, 3'b101, 3'b001);

        // consumer stalled through a full press/release
        base = got.size();
        drive(0, 1, 0, 15);
        drive(1, 1, 0, 10);
        @(posedge clk); #1;
        chk("stall_valid", int'(o_evt_valid), 1);
        chk("stall_data", int'(o_evt_data), 5);
        chk("stall_ovf", int'(o_ovf), 1);
        drive(1, 1, 1, 3);
        chk_events("stall", base, 1, 3'b101, 3'b000);
        chk("stall_ovf_sticky", int'(o_ovf), 1);
        @(negedge clk); #1; i_rst_n = 1'b0;
        drive(1, 1, 1, 2);
        chk("ovf_cleared", int'(o_ovf), 0);
        @(negedge clk); #1; i_rst_n = 1'b1;

        // ready only on the cycle the release issues (4th released sample)
        base = got.size();
        drive(0, 1, 0, 15);
        drive(1, 1, 0, 3);
        drive(1, 1, 1, 1);
        @(posedge clk); #1;
        chk("swap_valid", int'(o_evt_valid), 1);
        chk("swap_data", int'(o_evt_data), 1);
        chk("swap_ovf", int'(o_ovf), 0);
        chk_events("swap_press", base, 1, 3'b101, 3'b000);
        drive(1, 1, 0, 2);
        drive(1, 1, 1, 2);
        chk_events("swap", base, 2, 3'b101, 3'b001);

        // reset while HELD with a pending event, pad kept down across reset
        base = got.size();
        drive(0, 1, 0, 12);
        @(negedge clk); #1; i_rst_n = 1'b0;
        #1;
        chk("async_btn", int'(o_btn), 0);
        chk("async_valid", int'(o_evt_valid), 0);
        drive(0, 1, 1, 2);
        @(negedge clk); #1; i_rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("rearm_btn_early", int'(o_btn), 0);
        @(posedge clk); #1;
        chk("rearm_btn", int'(o_btn), 1);
        drive(0, 1, 1, 3);
        drive(1, 1, 1, 10);
        chk_events("rearm", base, 2, 3'b101, 3'b001);
      end

      begin
        #200000;
        $display("FAIL watchdog: got timeout expected scenario completion");
        errors++;
        checks++;
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
